regfile_dump_reader: RTL and testbench

- Debug read-side master for the CR16 register file (16 regs x 16 bits).
- On `start`, it asks the CPU to halt so the register file is frozen.
- It then walks the read port from FIRST_REG up to the top register and streams each word out on a valid/ready interface, e.g. to the debug UART or the 7-seg shell.
- It is the reader counterpart to the CPU writeback that fills the register file.

---
 rtl/regfile_dump_reader.sv | 79 +++++++
 tb/tb_regfile_dump_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Debug read master for the register file: halts the CPU, then streams
// registers FIRST_REG..top out over a valid/ready port, one word per READ+SEND pair.
module regfile_dump_reader #(
  parameter int WIDTH         = 16,
  parameter int REGISTER_BITS = 4,
  parameter int FIRST_REG     = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     haltRequest,
  input  logic                     haltAck,
  output logic [REGISTER_BITS-1:0] readAddress,
  input  logic [WIDTH-1:0]         readData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [WIDTH-1:0]         outData,
  output logic [REGISTER_BITS-1:0] outIndex,
  output logic                     outLast,
  output logic                     busy,
  output logic                     done
);

  localparam logic [REGISTER_BITS-1:0] FIRST = FIRST_REG[REGISTER_BITS-1:0];
  localparam logic [REGISTER_BITS-1:0] TOP   = {REGISTER_BITS{1'b1}};

  typedef enum logic [2:0] {IDLE, HALT_WAIT, READ, SEND, FINISH} state_t;
  state_t state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      haltRequest <= 1'b0;
      outValid    <= 1'b0;
      outLast     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      readAddress <= FIRST;
      outData     <= '0;
      outIndex    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state       <= HALT_WAIT;
          haltRequest <= 1'b1;
          busy        <= 1'b1;
          readAddress <= FIRST;
        end
        HALT_WAIT: if (haltAck) state <= READ;
        READ: begin
          outData  <= readData;
          outIndex <= readAddress;
          outLast  <= (readAddress == TOP);
          outValid <= 1'b1;
          state    <= SEND;
        end
        SEND: if (outReady) begin
          outValid <= 1'b0;
          // top address is terminal: release the CPU as we enter FINISH
          if (outLast) begin
            state       <= FINISH;
            done        <= 1'b1;
            haltRequest <= 1'b0;
          end else begin
            readAddress <= readAddress + 1'b1;
            state       <= READ;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized scoreboard bench: two readers (FIRST_REG 0 and 14) on a shared
// register-file model; a monitor pops expected words on every handshake.
module tb_regfile_dump_reader;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [1:0]  start, haltAck, outReady, haltRequest, outValid, outLast, busy, done;
  logic [3:0]  readAddress [2];
  logic [3:0]  outIndex [2];
  logic [15:0] readData [2];
  logic [15:0] outData [2];
  logic [15:0] regs [16];

  exp_t sbq [2][$];
  int   checks, passes;
  int   doneCnt [2];
  int   readyMode [2];
  int   phase [2];
  bit   held [2];
  bit   prevDone [2];
  exp_t heldWord [2];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign readData[g] = (readAddress[g] == 4'd0) ? 16'h0 : regs[readAddress[g]];
    regfile_dump_reader #(.WIDTH(16), .REGISTER_BITS(4), .FIRST_REG(g == 0 ? 0 : 14)) u_dut (
      .clock(clock), .reset(reset), .start(start[g]),
      .haltRequest(haltRequest[g]), .haltAck(haltAck[g]),
      .readAddress(readAddress[g]), .readData(readData[g]),
      .outValid(outValid[g]), .outReady(outReady[g]),
      .outData(outData[g]), .outIndex(outIndex[g]), .outLast(outLast[g]),
      .busy(busy[g]), .done(done[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int firstReg(input int g);
    return (g == 0) ? 0 : 14;
  endfunction

  // reference: a dump is the list of register contents from firstReg to 15
  task automatic push_dump(input int g);
    for (int i = firstReg(g); i < 16; i++)
      sbq[g].push_back('{data: (i == 0) ? 16'h0 : regs[i], idx: 4'(i), last: (i == 15)});
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      for (int g = 0; g < 2; g++) begin
        if (reset) begin
          held[g] = 0;
          prevDone[g] = 0;
        end else begin
          if (outValid[g]) begin
            if (held[g]) begin
              chk($sformatf("stable_data%0d", g), outData[g], heldWord[g].data);
              chk($sformatf("stable_idx%0d", g), outIndex[g], heldWord[g].idx);
              chk($sformatf("stable_last%0d", g), outLast[g], heldWord[g].last);
            end
            if (outReady[g]) begin
              held[g] = 0;
              if (sbq[g].size() == 0) chk($sformatf("extra_word%0d", g), outIndex[g], 32'hffff);
              else begin
                e = sbq[g].pop_front();
                chk($sformatf("data%0d", g), outData[g], e.data);
                chk($sformatf("idx%0d", g), outIndex[g], e.idx);
                chk($sformatf("last%0d", g), outLast[g], e.last);
              end
            end else begin
              held[g] = 1;
              heldWord[g] = '{data: outData[g], idx: outIndex[g], last: outLast[g]};
            end
          end else held[g] = 0;
          if (done[g]) begin
            doneCnt[g]++;
            chk($sformatf("busy_in_finish%0d", g), busy[g], 1);
            chk($sformatf("halt_low_finish%0d", g), haltRequest[g], 0);
          end else begin
            chk($sformatf("halt_vs_busy%0d", g), haltRequest[g], busy[g]);
          end
          if (prevDone[g]) chk($sformatf("idle_after_finish%0d", g), busy[g], 0);
          prevDone[g] = done[g];
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clock);
      #1;
      for (int g = 0; g < 2; g++) begin
        case (readyMode[g])
          0: outReady[g] = 1'b1;
          1: begin
            phase[g] = (phase[g] + 1) % 4;
            outReady[g] = (phase[g] == 0);
          end
          2: outReady[g] = 1'($urandom_range(0, 1));
          default: outReady[g] = (outIndex[g] != 4'd7);
        endcase
      end
    end
  endtask

  task automatic begin_dump(input int g);
    push_dump(g);
    @(posedge clock); #1;
    start[g] = 1'b1;
    @(posedge clock); #1;
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int target);
    int n = 0;
    while (doneCnt[g] < target && n < 3000) begin
      @(negedge clock); #1;
      n++;
    end
    chk($sformatf("done_count%0d", g), doneCnt[g], target);
  endtask

  task automatic randomize_regs();
    for (int i = 1; i < 16; i++) regs[i] = 16'($urandom);
  endtask

  initial begin
    int t;
    int n;
    bit seen;
    reset = 1'b1;
    start = '0; haltAck = '0; outReady = '0;
    for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
    for (int g = 0; g < 2; g++) begin
      readyMode[g] = 0; phase[g] = 0; doneCnt[g] = 0; held[g] = 0; prevDone[g] = 0;
    end
    fork
      monitor();
      ready_driver();
    join_none

    #12;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_valid%0d", g), outValid[g], 0);
      chk($sformatf("rst_halt%0d", g), haltRequest[g], 0);
      chk($sformatf("rst_busy%0d", g), busy[g], 0);
      chk($sformatf("rst_done%0d", g), done[g], 0);
      chk($sformatf("rst_last%0d", g), outLast[g], 0);
      chk($sformatf("rst_addr%0d", g), readAddress[g], firstReg(g));
      chk($sformatf("rst_data%0d", g), outData[g], 0);
      chk($sformatf("rst_idx%0d", g), outIndex[g], 0);
    end
    @(negedge clock); reset = 1'b0;

    // plain dump, consumer always ready, ack two cycles after start
    begin_dump(0);
    chk("halt_after_start", haltRequest[0], 1);
    chk("busy_after_start", busy[0], 1);
    @(posedge clock); #1; haltAck[0] = 1'b1;
    wait_done(0, 1);
    chk("sb_drained_a", sbq[0].size(), 0);
    haltAck[0] = 1'b0;

    // stalled consumer plus a stray start while words are in flight
    randomize_regs();
    readyMode[0] = 1;
    begin_dump(0);
    @(posedge clock); #1; haltAck[0] = 1'b1;
    n = 0;
    while (!outValid[0] && n < 50) begin @(negedge clock); n++; end
    chk("first_valid_seen", outValid[0], 1);
    @(posedge clock); #1; start[0] = 1'b1;
    @(posedge clock); #1; start[0] = 1'b0;
    wait_done(0, 2);
    repeat (4) @(posedge clock);
    chk("no_stray_dump", doneCnt[0], 2);
    chk("sb_drained_b", sbq[0].size(), 0);
    haltAck[0] = 1'b0;

    // long halt wait with a start pulse inside it
    randomize_regs();
    readyMode[0] = 2;
    begin_dump(0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (outValid[0]) seen = 1;
      if (c == 5) begin @(posedge clock); #1; start[0] = 1'b1; end
      if (c == 6) begin @(posedge clock); #1; start[0] = 1'b0; end
    end
    chk("no_valid_in_wait", seen, 0);
    chk("addr_in_wait", readAddress[0], 0);
    chk("busy_in_wait", busy[0], 1);
    chk("halt_in_wait", haltRequest[0], 1);
    @(posedge clock); #1; haltAck[0] = 1'b1;
    wait_done(0, 3);
    chk("sb_drained_c", sbq[0].size(), 0);

    // reader starting at register 14
    randomize_regs();
    haltAck[1] = 1'b1;
    begin_dump(1);
    wait_done(1, 1);
    repeat (3) @(posedge clock);
    chk("sb_drained_14", sbq[1].size(), 0);
    chk("single_done_14", doneCnt[1], 1);

    // reset while word 7 is waiting for acceptance
    readyMode[0] = 3;
    t = doneCnt[0];
    begin_dump(0);
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clock); n++;
      seen = outValid[0] && (outIndex[0] == 4'd7);
    end
    chk("reached_idx7", seen, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", outValid[0], 0);
    chk("async_halt", haltRequest[0], 0);
    chk("async_busy", busy[0], 0);
    chk("async_done", done[0], 0);
    chk("async_addr", readAddress[0], 0);
    sbq[0].delete();
    @(negedge clock); #2 reset = 1'b0;
    chk("no_done_on_abort", doneCnt[0], t);
    readyMode[0] = 2;
    begin_dump(0);
    wait_done(0, t + 1);
    chk("sb_drained_d", sbq[0].size(), 0);

    // start held high: two back-to-back dumps
    randomize_regs();
    push_dump(0);
    push_dump(0);
    @(posedge clock); #1; start[0] = 1'b1;
    wait_done(0, t + 2);
    wait_done(0, t + 3);
    start[0] = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("held_start_dumps", doneCnt[0], t + 3);
    chk("held_start_idle", busy[0], 0);
    chk("sb_drained_e", sbq[0].size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
